// File: rtl/base2exp.sv
// Sequential 2^x for an unsigned fixed-point exponent: one fraction bit per CALC cycle, then a shift.
// Define BASE2EXP_SATURATE_EN to clamp results that exceed 32 bits and flag overflow_o.
module base2exp #(
    parameter int FRAC_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FRAC_BITS+4:0] log_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [31:0]          number_o,
    output logic                 overflow_o,
    output logic                 valid_o,
    input  logic                 ready_i
);
    localparam logic [16:0] M_ONE  = 17'd65536;
    localparam logic [3:0]  LAST_K = 4'(FRAC_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SHIFT,
        S_DONE
    } state_t;

    // round(2^(2^-k) * 65536), the Q1.16 factor for fraction bit k (MSB is k=1)
    function automatic logic [16:0] calc_const(input logic [3:0] k);
        case (k)
            4'd1:    return 17'd92682;
            4'd2:    return 17'd77936;
            4'd3:    return 17'd71468;
            4'd4:    return 17'd68438;
            4'd5:    return 17'd66971;
            4'd6:    return 17'd66250;
            4'd7:    return 17'd65892;
            4'd8:    return 17'd65714;
            default: return M_ONE;
        endcase
    endfunction

    function automatic logic [16:0] mant_step(input logic [16:0] m, input logic [3:0] k);
        return 17'((34'(m) * 34'(calc_const(k))) >> 16);
    endfunction

`ifdef BASE2EXP_SATURATE_EN
    function automatic logic [32:0] scale_sat(input logic [16:0] m, input logic [4:0] e);
        logic [47:0] r;
        r = (48'(m) << e) >> 16;
        if (r[47:32] != 16'd0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, r[31:0]};
    endfunction
`else
    function automatic logic [31:0] scale_wrap(input logic [16:0] m, input logic [4:0] e);
        return 32'((48'(m) << e) >> 16);
    endfunction
`endif

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [4:0]           exp_q, exp_d;
    logic [FRAC_BITS-1:0] frac_q, frac_d;
    logic [16:0]          m_q, m_d;
    logic [31:0]          number_q, number_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;
`ifdef BASE2EXP_SATURATE_EN
    logic                 overflow_q, overflow_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        frac_d   = frac_q;
        m_d      = m_q;
        number_d = number_q;
        valid_d  = valid_q;
        ready_d  = ready_q;
`ifdef BASE2EXP_SATURATE_EN
        overflow_d = overflow_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    exp_d   = log_i[FRAC_BITS+4:FRAC_BITS];
                    frac_d  = log_i[FRAC_BITS-1:0];
                    m_d     = M_ONE;
                    cnt_d   = 4'd0;
                    ready_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // The step runs every cycle so latency never depends on the fraction value.
                if (frac_q[FRAC_BITS-1]) m_d = mant_step(m_q, cnt_q + 4'd1);
                frac_d = frac_q << 1;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_K) state_d = S_SHIFT;
            end
            S_SHIFT: begin
`ifdef BASE2EXP_SATURATE_EN
                {overflow_d, number_d} = scale_sat(m_q, exp_q);
`else
                number_d = scale_wrap(m_q, exp_q);
`endif
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            m_q      <= M_ONE;
            number_q <= 32'd0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
`ifdef BASE2EXP_SATURATE_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            number_q <= number_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
`ifdef BASE2EXP_SATURATE_EN
            overflow_q <= overflow_d;
`endif
        end
    end

    // Operand registers are only read after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        exp_q  <= exp_d;
        frac_q <= frac_d;
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign number_o = number_q;
`ifdef BASE2EXP_SATURATE_EN
    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_base2exp.sv
// Self-checking bench for base2exp (FRAC_BITS=4): directed cases, backpressure, reset, full sweep.
module tb_base2exp;
    localparam int FB = 4;
    localparam int unsigned CK [8] = '{92682, 77936, 71468, 68438, 66971, 66250, 65892, 65714};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  log_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] number_o;
    logic        overflow_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    int errors = 0;
    int checks = 0;

    base2exp #(.FRAC_BITS(FB)) dut (
        .clk(clk),
        .rst(rst),
        .log_i(log_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .number_o(number_o),
        .overflow_o(overflow_o),
        .valid_o(valid_o),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    // floor(2^(E+F)) built from the mantissa rules with 64-bit integers
    function automatic void model(input logic [8:0] v, output logic [31:0] num, output logic ovf);
        longint unsigned m, r;
        m = 65536;
        for (int k = 1; k <= FB; k++)
            if (v[FB-k]) m = (m * CK[k-1]) >> 16;
        r = (m << v[8:4]) >> 16;
`ifdef BASE2EXP_SATURATE_EN
        if (r > 64'h0000_0000_FFFF_FFFF) begin
            num = 32'hFFFF_FFFF;
            ovf = 1'b1;
        end else begin
            num = r[31:0];
            ovf = 1'b0;
        end
`else
        num = r[31:0];
        ovf = 1'b0;
`endif
    endfunction

    // Runs one transaction, injecting valid_i/log_i noise while busy; reports observations only.
    task automatic drive_op(input logic [8:0] v, input int stall, output logic [31:0] num,
                            output logic ovf, output int lat, output int early_rdy,
                            output int unstable, output int handoff_bad);
        int w;
        w = 0;
        early_rdy = 0;
        unstable = 0;
        handoff_bad = 0;
        while (ready_o !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        log_i = v;
        valid_i = 1'b1;
        ready_i = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        valid_i = 1'($urandom_range(0, 1));
        log_i = 9'($urandom);
        if (ready_o !== 1'b0) early_rdy++;
        while (valid_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            valid_i = 1'($urandom_range(0, 1));
            log_i = 9'($urandom);
            if (ready_o !== 1'b0) early_rdy++;
        end
        num = number_o;
        ovf = overflow_o;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            valid_i = 1'($urandom_range(0, 1));
            if (number_o !== num || overflow_o !== ovf || valid_o !== 1'b1 || ready_o !== 1'b0)
                unstable++;
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        valid_i = 1'b0;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || number_o !== num || overflow_o !== ovf)
            handoff_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || number_o !== 32'd0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b num=%h ovf=%b, required rdy=1 vld=0 num=0 ovf=0",
                     ready_o, valid_o, number_o, overflow_o);
        end
    endtask

    task automatic test_basic();
        logic [8:0]  vals [3] = '{9'h000, 9'h050, 9'h1F0};
        logic [31:0] exps [3] = '{32'd1, 32'd32, 32'h8000_0000};
        logic [31:0] num;
        logic        ovf;
        int lat, er, us, hb;
        for (int i = 0; i < 3; i++) begin
            drive_op(vals[i], 0, num, ovf, lat, er, us, hb);
            checks++;
            if (num !== exps[i] || ovf !== 1'b0) begin
                errors++;
                $display("FAIL basic_%h: num=%h ovf=%b, required num=%h ovf=0", vals[i], num, ovf, exps[i]);
            end
            checks++;
            if (lat !== FB + 2) begin
                errors++;
                $display("FAIL latency_%h: valid_o at cycle %0d, required %0d", vals[i], lat, FB + 2);
            end
            checks++;
            if (er !== 0 || hb !== 0) begin
                errors++;
                $display("FAIL handshake_%h: early_ready=%0d handoff_bad=%0d, required 0/0", vals[i], er, hb);
            end
        end
    endtask

    task automatic test_fraction();
        logic [8:0]  vals [2] = '{9'h0A8, 9'h008};
        logic [31:0] exps [2] = '{32'd1448, 32'd1};
        logic [31:0] num;
        logic        ovf;
        int lat, er, us, hb;
        for (int i = 0; i < 2; i++) begin
            drive_op(vals[i], 0, num, ovf, lat, er, us, hb);
            checks++;
            if (num !== exps[i]) begin
                errors++;
                $display("FAIL fraction_%h: num=%0d, required %0d", vals[i], num, exps[i]);
            end
        end
    endtask

    // E=31 with the largest mantissa: the model decides whether it leaves 32 bits.
    task automatic test_overflow();
        logic [31:0] num, enum_v;
        logic        ovf, eovf;
        int lat, er, us, hb;
        model(9'h1FF, enum_v, eovf);
        drive_op(9'h1FF, 0, num, ovf, lat, er, us, hb);
        checks++;
        if (num !== enum_v || ovf !== eovf) begin
            errors++;
            $display("FAIL overflow_1ff: num=%h ovf=%b, required num=%h ovf=%b", num, ovf, enum_v, eovf);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] num;
        logic        ovf;
        int lat, er, us, hb;
        drive_op(9'h0A8, 10, num, ovf, lat, er, us, hb);
        checks++;
        if (num !== 32'd1448) begin
            errors++;
            $display("FAIL bp_value: num=%0d, required 1448", num);
        end
        checks++;
        if (us !== 0 || er !== 0) begin
            errors++;
            $display("FAIL bp_hold: unstable cycles=%0d early_ready=%0d, required 0/0", us, er);
        end
        checks++;
        if (hb !== 0) begin
            errors++;
            $display("FAIL bp_release: handoff_bad=%0d, required 0", hb);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] num;
        logic        ovf;
        int lat, er, us, hb, seen;
        log_i = 9'h0A8;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || number_o !== 32'd0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_calc_state: rdy=%b vld=%b num=%h ovf=%b, required 1/0/0/0",
                     ready_o, valid_o, number_o, overflow_o);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_mid_calc_discard: %0d cycles with activity, required 0", seen);
        end
        drive_op(9'h050, 0, num, ovf, lat, er, us, hb);
        checks++;
        if (num !== 32'd32 || lat !== FB + 2) begin
            errors++;
            $display("FAIL rst_then_050: num=%0d lat=%0d, required 32 lat %0d", num, lat, FB + 2);
        end
    endtask

    task automatic test_sweep();
        int order [512];
        logic [31:0] num, enum_v;
        logic        ovf, eovf;
        int lat, er, us, hb, j, t, bad_hs;
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        bad_hs = 0;
        for (int i = 0; i < 512; i++) begin
            model(9'(order[i]), enum_v, eovf);
            drive_op(9'(order[i]), int'($urandom_range(0, 2)), num, ovf, lat, er, us, hb);
            checks++;
            if (num !== enum_v || ovf !== eovf) begin
                errors++;
                $display("FAIL sweep_%h: num=%h ovf=%b, required num=%h ovf=%b",
                         9'(order[i]), num, ovf, enum_v, eovf);
            end
            checks++;
            if (lat !== FB + 2) begin
                errors++;
                $display("FAIL sweep_lat_%h: valid_o at cycle %0d, required %0d", 9'(order[i]), lat, FB + 2);
            end
            bad_hs += er + us + hb;
        end
        checks++;
        if (bad_hs !== 0) begin
            errors++;
            $display("FAIL sweep_handshake: %0d protocol violations, required 0", bad_hs);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fraction();
        test_overflow();
        test_backpressure();
        test_reset_mid_calc();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
